// File: rtl/cfg_frame_pkg.sv
// rtl/cfg_frame_pkg.sv - shared frame state encoding and frame-length helper
package cfg_frame_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;

  // Shared with the receiver so both ends agree on the frame length.
  function automatic int frame_bits(input int data_w, input int par_en, input int stop_bits);
    return 1 + data_w + par_en + stop_bits;
  endfunction

endpackage

// File: rtl/cfg_frame_tick.sv
// rtl/cfg_frame_tick.sv - bit-period down-counter; tick marks the last clock of each bit
module cfg_frame_tick #(
  parameter int DIV   = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || (en && cnt == '0)) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/cfg_frame_tx.sv
// rtl/cfg_frame_tx.sv - serial frame transmitter: start, LSB-first data, optional parity, stop
module cfg_frame_tx
  import cfg_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy
);

  localparam int DIV_W      = $clog2(DIV + 1);
  localparam int BIT_W      = $clog2(DATA_W + 1);
  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY_EN, STOP_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  if (DIV < 1) begin : g_bad_div
    $error("cfg_frame_tx: DIV must be >= 1");
  end
  if (DATA_W < 1 || DATA_W > 32 || STOP_BITS < 1 || STOP_BITS > 2 || FRAME_BITS > 36) begin : g_bad_frame
    $error("cfg_frame_tx: DATA_W must be 1..32 and STOP_BITS 1..2");
  end

  frame_state_t      state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              par_bit;
  logic              tick;

  cfg_frame_tick #(
    .DIV   (DIV),
    .CNT_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE),
    .en    (state != IDLE),
    .tick  (tick)
  );

  assign shift_nxt = shift >> 1;
  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;

  // tx is registered: each edge loads the level for the period that starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= START;
            tx       <= 1'b0;
            shift    <= in_data;
            par_bit  <= (^in_data) ^ 1'(PARITY_ODD);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift_nxt;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= BIT_W'(DATA_W);
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_nxt[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_frame_tx.sv
// tb/tb_cfg_frame_tx.sv - scoreboard bench for cfg_frame_tx over four parameter sets
module tb_cfg_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data [4];
  logic [3:0]  tx_w, rdy_w, busy_w;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // Per-instance parameters: default, odd parity, no parity, DIV=1/DATA_W=5/2 stop bits.
  int dw_t  [4] = '{8, 8, 8, 5};
  int div_t [4] = '{4, 4, 4, 1};
  int pen_t [4] = '{1, 1, 0, 1};
  int podd_t[4] = '{0, 1, 0, 0};
  int sb_t  [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  cfg_frame_tx u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy_w[0]),
                   .in_data(in_data[0][7:0]), .tx(tx_w[0]), .busy(busy_w[0]));
  cfg_frame_tx #(.PARITY_ODD(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy_w[1]),
                   .in_data(in_data[1][7:0]), .tx(tx_w[1]), .busy(busy_w[1]));
  cfg_frame_tx #(.PARITY_EN(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy_w[2]),
                   .in_data(in_data[2][7:0]), .tx(tx_w[2]), .busy(busy_w[2]));
  cfg_frame_tx #(.DATA_W(5), .DIV(1), .STOP_BITS(2)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]),
                   .in_ready(rdy_w[3]), .in_data(in_data[3][4:0]), .tx(tx_w[3]), .busy(busy_w[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int k, input logic [31:0] d);
    bit p;
    p = podd_t[k][0];
    repeat (div_t[k]) exp_q.push_back(1'b0);
    for (int i = 0; i < dw_t[k]; i++) begin
      p ^= d[i];
      repeat (div_t[k]) exp_q.push_back(d[i]);
    end
    if (pen_t[k] != 0) repeat (div_t[k]) exp_q.push_back(p);
    repeat (div_t[k] * sb_t[k]) exp_q.push_back(1'b1);
  endtask

  // Checks every clock of the frame against the scoreboard, then the idle clock.
  task automatic send(input int k, input logic [31:0] d, input int frame_clks);
    bit e;
    push_frame(k, d);
    chk("frame_len", exp_q.size(), frame_clks);
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_data[k]  = 'x;
      e = exp_q.pop_front();
      chk("tx_bit", tx_w[k], e);
      chk("ready_low", rdy_w[k], 0);
      chk("busy_high", busy_w[k], 1);
    end
    @(negedge clk);
    chk("idle_tx", tx_w[k], 1);
    chk("idle_ready", rdy_w[k], 1);
    in_data[k] = '0;
  endtask

  initial begin
    bit e;
    rst_n    = 1'b0;
    in_valid = '0;
    for (int k = 0; k < 4; k++) in_data[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_tx", tx_w[k], 1);
      chk("rst_ready", rdy_w[k], 1);
      chk("rst_busy", busy_w[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 32'hA5, 44);
    send(1, 32'h00, 44);
    send(1, 32'hFF, 44);
    send(2, 32'h0F, 40);
    send(3, 32'h15, 9);

    // Back-to-back with in_valid held high; in_data switches mid-frame.
    push_frame(0, 32'h12);
    exp_q.push_back(1'b1);
    push_frame(0, 32'h34);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h12;
    for (int i = 0; i < 89; i++) begin
      @(negedge clk);
      if (i == 10) in_data[0] = 32'h34;
      if (i == 46) in_valid[0] = 1'b0;
      e = exp_q.pop_front();
      chk("b2b_tx", tx_w[0], e);
      chk("b2b_ready", rdy_w[0], (i == 44) ? 1 : 0);
    end
    @(negedge clk);
    chk("b2b_idle", rdy_w[0], 1);

    // Reset in the middle of data bit 3.
    push_frame(0, 32'hA5);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hA5;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      e = exp_q.pop_front();
      chk("pre_rst_tx", tx_w[0], e);
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx_w[0], 1);
    chk("async_rst_ready", rdy_w[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy_w[0], 1);
    chk("post_rst_tx", tx_w[0], 1);
    send(0, 32'h3C, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_frame_tx.md
Name: cfg_frame_tx

Overview:
- Serial frame transmitter.
- Accepts a parallel word on a valid/ready input and drives it onto a single-wire line: start bit, DATA_W data bits LSB-first, optional parity, STOP_BITS stop bits.
- Each bit is held for DIV clocks.
- Paired with the existing frame receiver in the intf-param-xref test set. Exercises header-parameter overrides against body-local derived constants on the driving side.

Parameters:
- DATA_W, 8, payload bits per frame; legal 1..32.
- DIV, 4, clocks per serial bit; legal >=1. DIV=0 raises an elaboration $error.
- PARITY_EN, 1, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits per frame; legal 1..2.
- Derived constants are body localparams, not overridable:
  - DIV_W = $clog2(DIV+1)
  - BIT_W = $clog2(DATA_W+1)
  - FRAME_BITS = 1 + DATA_W + PARITY_EN + STOP_BITS

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, word offered.
- in_ready, output, 1, transmitter can accept a word.
- in_data, input, DATA_W, word to send; sampled only on accept.
- tx, output, 1, serial line; idle high.
- busy, output, 1, frame in progress.

Behaviour:
- Reset (async assert, sync-to-clk release): state IDLE, tx=1, in_ready=1, busy=0, counters 0, shift register 0.
- Accept occurs when in_valid && in_ready at a rising edge. in_data is latched into the shift register; in_data and in_valid are ignored afterwards until the next IDLE.
- in_ready = (state==IDLE). busy = !in_ready. Both are registered-state decodes with no combinational path from in_valid.
- FSM states and transitions:
  - IDLE: on accept -> START.
  - START: tx=0 for DIV clocks -> DATA.
  - DATA: tx=shift[0] for DIV clocks per bit; shift right after each bit. After DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx = ^data_latched ^ PARITY_ODD for DIV clocks -> STOP.
  - STOP: tx=1 for DIV*STOP_BITS clocks -> IDLE.
- Latency: tx falls on the first clock after the accept edge.
- Frame duration is exactly DIV*FRAME_BITS clocks. Every bit is held exactly DIV clocks, with no jitter.
- Back-to-back frames: IDLE lasts at least 1 clock, with tx=1 and in_ready=1. If in_valid is held high, frames are spaced DIV*FRAME_BITS+1 clocks apart.
- The divider counter counts DIV-1 down to 0, then reloads. DIV=1 means a bit changes every clock.
- The bit counter saturates at DATA_W and never wraps into the next frame.
- Parity is computed over the latched word, not over live in_data.
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the partial frame is discarded. No resume.
- in_valid asserted while busy has no effect; the word is not queued.
- X on in_data outside the accept cycle must not propagate to tx.

Decomposition:
- Package cfg_frame_pkg holds:
  - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t
  - function frame_bits(data_w, par_en, stop_bits), shared with the receiver so both ends agree on frame length.
- One sub-module, cfg_frame_tick: the DIV down-counter with load/enable inputs and a tick output asserted on the last clock of each bit period.
- The FSM and shift register stay in cfg_frame_tx.

Test Plan:
- Defaults, send 0xA5 -> tx over 44 clocks: 0, then 1,0,1,0,0,1,0,1, then parity 0 (four ones, even), then stop 1; each level held 4 clocks. in_ready=0 for exactly 44 clocks.
- PARITY_ODD=1, send 0x00 -> parity bit 1; send 0xFF -> parity bit 1. With PARITY_EN=0, send 0x0F -> frame is 40 clocks with no parity slot.
- in_valid held high with words 0x12 then 0x34 -> start-bit falling edges are exactly 45 clocks apart, with one idle-high clock between frames. in_data changes mid-frame do not alter the bits sent.
- DIV=1, STOP_BITS=2, DATA_W=5, send 5'h15 -> 9-clock frame: 0,1,0,1,0,1,P=1,1,1.
- rst_n pulled low during data bit 3 of 0xA5 -> tx=1 asynchronously, in_ready=1 after release. The next accepted word 0x3C is sent correctly.
- Instantiation that overrides BIT_W or FRAME_BITS -> elaboration/lint error (localparam). Override of DIV=0 -> $error.
